// File: rtl/spi_tx_arb_pkg.sv
// Shared definitions for the SPI transmit arbiter slice.
// Holds the one-hot FSM state encodings, the default byte width and the
// helper that sizes the optional ack-timeout counter.
package spi_tx_arb_pkg;

  localparam int DEF_BUS_DATA_WIDTH = 8;

  // One-hot so each state is a single flop bit.
  typedef enum logic [3:0] {
    IDLE     = 4'b0001,
    WAIT_ACK = 4'b0010,
    ACK      = 4'b0100,
    BURST    = 4'b1000
  } state_t;

  // Timeout counter is kept between 8 and 16 bits wide.
  function automatic int ack_cnt_width(input int timeout);
    int w;
    w = $clog2(timeout + 1);
    if (w < 8) w = 8;
    if (w > 16) w = 16;
    return w;
  endfunction

endpackage

// File: rtl/spi_tx_arb_if.sv
// Bundle of the handler-side and SPI-core-side signals of spi_tx_arb.
// master: arbiter view (drives req_ack, tx_*, grant_id, busy, timeout_err).
// slave : environment view (handlers plus SPI byte core).
interface spi_tx_arb_if
  import spi_tx_arb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int BUS_DATA_WIDTH = DEF_BUS_DATA_WIDTH
) ();

  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]                req_valid;
  logic [NUM_REQ*BUS_DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]                req_last;
  logic [NUM_REQ-1:0]                req_ack;
  logic [BUS_DATA_WIDTH-1:0]         tx_data;
  logic                              tx_req;
  logic                              tx_ack;
  logic                              rx_end;
  logic [ID_W-1:0]                   grant_id;
  logic                              busy;
  logic                              timeout_err;

  modport master (
    input  req_valid, req_data, req_last, tx_ack, rx_end,
    output req_ack, tx_data, tx_req, grant_id, busy, timeout_err
  );

  modport slave (
    output req_valid, req_data, req_last, tx_ack, rx_end,
    input  req_ack, tx_data, tx_req, grant_id, busy, timeout_err
  );

endinterface

// File: rtl/spi_tx_arb_rr_pick.sv
// rr_pick: combinational round-robin selector, reusable by any arbiter.
// Latency: none (pure combinational). Backpressure: n/a.
// Ports: req (request vector), ptr (last winner) -> any (some request set),
// idx (first set request searching upward from ptr+1, wrapping at N).
module rr_pick #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          any,
  output logic [IW-1:0] idx
);

  localparam logic [IW-1:0] LAST = IW'(N - 1);

  logic [IW-1:0] cand;

  // Walk the N positions after ptr; the first hit wins, later hits are ignored.
  always_comb begin
    any  = 1'b0;
    idx  = ptr;
    cand = ptr;
    for (int k = 0; k < N; k++) begin
      cand = (cand == LAST) ? '0 : cand + 1'b1;
      if (!any && req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/spi_tx_arb.sv
// spi_tx_arb: round-robin arbiter sharing the SPI slave tx byte path among
// NUM_REQ handlers, holding the grant for a burst until req_last or rx_end.
// Latency: tx_req one edge after req_valid is sampled in IDLE; req_ack one
// edge after tx_ack. Backpressure: a byte waits in WAIT_ACK until tx_ack,
// rx_end, or (with SPI_TX_ARB_TIMEOUT_EN defined) ACK_TIMEOUT cycles.
// Ports: clk, rst (async, active-high), bus (spi_tx_arb_if.master):
// req_valid/req_data/req_last/req_ack to handlers, tx_data/tx_req/tx_ack/
// rx_end to the SPI core, grant_id/busy/timeout_err status.
module spi_tx_arb
  import spi_tx_arb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int BUS_DATA_WIDTH = DEF_BUS_DATA_WIDTH,
  parameter int ACK_TIMEOUT    = 255
) (
  input  logic         clk,
  input  logic         rst,
  spi_tx_arb_if.master bus
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int W  = BUS_DATA_WIDTH;

  state_t               state_q, state_n;
  logic [IW-1:0]        ptr_q, ptr_n;
  logic [IW-1:0]        grant_q, grant_n;
  logic [W-1:0]         data_q, data_n;
  logic                 tx_req_q, tx_req_n;
  logic [NUM_REQ-1:0]   ack_q, ack_n;
  logic                 busy_q, busy_n;
  logic                 last_q, last_n;
  logic                 rx_seen_q, rx_seen_n;
  logic                 rel_grant;
  logic                 pick_any;
  logic [IW-1:0]        pick_idx;
  logic [W-1:0]         data_arr [NUM_REQ];

`ifdef SPI_TX_ARB_TIMEOUT_EN
  localparam int              CNT_W     = ack_cnt_width(ACK_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(ACK_TIMEOUT);
  logic [CNT_W-1:0] cnt_q, cnt_n, cnt_inc;
  logic             terr_q, terr_n;
  assign cnt_inc = cnt_q + 1'b1;
`else
  localparam int unused_ack_timeout = ACK_TIMEOUT;
`endif

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign data_arr[i] = bus.req_data[i*W +: W];
  end

  rr_pick #(.N(NUM_REQ)) u_pick (
    .req (bus.req_valid),
    .ptr (ptr_q),
    .any (pick_any),
    .idx (pick_idx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= IW'(NUM_REQ - 1);
      grant_q   <= '0;
      data_q    <= '0;
      tx_req_q  <= 1'b0;
      ack_q     <= '0;
      busy_q    <= 1'b0;
      last_q    <= 1'b0;
      rx_seen_q <= 1'b0;
`ifdef SPI_TX_ARB_TIMEOUT_EN
      cnt_q     <= '0;
      terr_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_n;
      ptr_q     <= ptr_n;
      grant_q   <= grant_n;
      data_q    <= data_n;
      tx_req_q  <= tx_req_n;
      ack_q     <= ack_n;
      busy_q    <= busy_n;
      last_q    <= last_n;
      rx_seen_q <= rx_seen_n;
`ifdef SPI_TX_ARB_TIMEOUT_EN
      cnt_q     <= cnt_n;
      terr_q    <= terr_n;
`endif
    end
  end

  always_comb begin
    state_n   = state_q;
    ptr_n     = ptr_q;
    grant_n   = grant_q;
    data_n    = data_q;
    tx_req_n  = tx_req_q;
    ack_n     = '0;
    busy_n    = busy_q;
    last_n    = last_q;
    rx_seen_n = rx_seen_q;
    rel_grant = 1'b0;
`ifdef SPI_TX_ARB_TIMEOUT_EN
    cnt_n     = cnt_q;
    terr_n    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          grant_n   = pick_idx;
          data_n    = data_arr[pick_idx];
          last_n    = bus.req_last[pick_idx];
          tx_req_n  = 1'b1;
          busy_n    = 1'b1;
          rx_seen_n = 1'b0;
          state_n   = WAIT_ACK;
`ifdef SPI_TX_ARB_TIMEOUT_EN
          cnt_n     = '0;
`endif
        end
      end
      WAIT_ACK: begin
        // tx_ack wins over rx_end: the byte is acked, and the ended
        // transaction is remembered so ACK releases afterwards.
        if (bus.tx_ack) begin
          tx_req_n       = 1'b0;
          ack_n[grant_q] = 1'b1;
          rx_seen_n      = bus.rx_end;
          state_n        = ACK;
        end else if (bus.rx_end) begin
          tx_req_n  = 1'b0;
          rel_grant = 1'b1;
        end
`ifdef SPI_TX_ARB_TIMEOUT_EN
        else if (cnt_inc == CNT_LIMIT) begin
          tx_req_n  = 1'b0;
          terr_n    = 1'b1;
          rel_grant = 1'b1;
        end else begin
          cnt_n = cnt_inc;
        end
`endif
      end
      ACK: begin
        // Handler swaps in its next byte during this cycle.
        if (last_q || rx_seen_q || bus.rx_end) rel_grant = 1'b1;
        else                                   state_n   = BURST;
      end
      BURST: begin
        // Only the burst owner is looked at; others wait for release.
        if (bus.req_valid[grant_q]) begin
          data_n   = data_arr[grant_q];
          last_n   = bus.req_last[grant_q];
          tx_req_n = 1'b1;
          state_n  = WAIT_ACK;
`ifdef SPI_TX_ARB_TIMEOUT_EN
          cnt_n    = '0;
`endif
        end else if (bus.rx_end) begin
          rel_grant = 1'b1;
        end
      end
      default: begin
        tx_req_n = 1'b0;
        busy_n   = 1'b0;
        state_n  = IDLE;
      end
    endcase
    // Release parks the pointer on the last owner; grant_id is kept.
    if (rel_grant) begin
      ptr_n   = grant_q;
      busy_n  = 1'b0;
      state_n = IDLE;
    end
  end

  assign bus.tx_data  = data_q;
  assign bus.tx_req   = tx_req_q;
  assign bus.req_ack  = ack_q;
  assign bus.grant_id = grant_q;
  assign bus.busy     = busy_q;
`ifdef SPI_TX_ARB_TIMEOUT_EN
  assign bus.timeout_err = terr_q;
`else
  assign bus.timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_spi_tx_arb.sv
// Bench for spi_tx_arb: handlers are byte queues, the SPI core is played by
// the bench, and a transaction-level round-robin model predicts each grant.
module tb_spi_tx_arb;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_tx_arb_if #(.NUM_REQ(N), .BUS_DATA_WIDTH(8)) bus ();

  spi_tx_arb #(.NUM_REQ(N), .BUS_DATA_WIDTH(8), .ACK_TIMEOUT(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Handler byte queues and transaction-level model state.
  logic [7:0] hd [N][16];
  bit         hl [N][16];
  int         hcnt [N];
  int         hpos [N];
  int         m_ptr;
  int         m_own;
  int         acks [N];
  int         glog [$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_handlers();
    for (int i = 0; i < N; i++) begin
      if (hpos[i] < hcnt[i]) begin
        bus.req_valid[i]       = 1'b1;
        bus.req_data[i*8 +: 8] = hd[i][hpos[i]];
        bus.req_last[i]        = hl[i][hpos[i]];
      end else begin
        bus.req_valid[i]       = 1'b0;
        bus.req_data[i*8 +: 8] = 8'h00;
        bus.req_last[i]        = 1'b0;
      end
    end
  endtask

  task automatic load(input int h, input logic [7:0] d, input bit last);
    hd[h][hcnt[h]] = d;
    hl[h][hcnt[h]] = last;
    hcnt[h]++;
  endtask

  task automatic clear_queues();
    for (int i = 0; i < N; i++) begin
      hcnt[i] = 0;
      hpos[i] = 0;
    end
    drive_handlers();
  endtask

  function automatic bit pending();
    for (int i = 0; i < N; i++)
      if (hpos[i] < hcnt[i]) return 1'b1;
    return 1'b0;
  endfunction

  // Reference arbitration: first handler with queued bytes after the pointer.
  function automatic int pick_next(input int p);
    for (int k = 1; k <= N; k++)
      if (hpos[(p + k) % N] < hcnt[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    bus.tx_ack = 1'b0;
    bus.rx_end = 1'b0;
    clear_queues();
    tick();
    tick();
    rst = 1'b0;
    m_ptr = N - 1;
    m_own = -1;
  endtask

  task automatic wait_grant(output int lat);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!bus.tx_req && lat < 20);
    if (!bus.tx_req) check_eq("tx_req_wait", 0, 1);
  endtask

  // mode 0: tx_ack, 1: tx_ack with rx_end, 2: rx_end only (abort)
  task automatic run_byte(input int dly, input int mode);
    int g;
    int lat;
    bit rel;
    logic [3:0] exp_ack;
    g = (m_own >= 0) ? m_own : pick_next(m_ptr);
    if (g < 0) begin
      check_eq("no_pending", 0, 1);
      return;
    end
    wait_grant(lat);
    check_eq("grant_lat", lat, 1);
    if (!bus.tx_req) return;
    check_eq("grant_id", bus.grant_id, g);
    check_eq("tx_data", bus.tx_data, hd[g][hpos[g]]);
    check_eq("busy_on", bus.busy, 1);
    glog.push_back(int'(bus.grant_id));
    repeat (dly) begin
      tick();
      check_eq("tx_req_hold", bus.tx_req, 1);
      check_eq("no_early_ack", bus.req_ack, 0);
    end
    bus.tx_ack = (mode != 2);
    bus.rx_end = (mode != 0);
    tick();
    bus.tx_ack = 1'b0;
    bus.rx_end = 1'b0;
    check_eq("tx_req_drop", bus.tx_req, 0);
    if (mode == 2) begin
      check_eq("abort_no_ack", bus.req_ack, 0);
      check_eq("abort_busy", bus.busy, 0);
      m_ptr = g;
      m_own = -1;
      return;
    end
    exp_ack = 4'b0001 << g;
    check_eq("req_ack", bus.req_ack, exp_ack);
    acks[g] += int'(bus.req_ack[g]);
    rel = hl[g][hpos[g]] || (mode == 1);
    hpos[g]++;
    drive_handlers();
    tick();
    check_eq("req_ack_pulse", bus.req_ack, 0);
    check_eq("busy_after", bus.busy, !rel);
    if (rel) begin
      m_ptr = g;
      m_own = -1;
    end else begin
      m_own = g;
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base;
    int a1;
    int lat;
    int n;
    int terr;
    int na;
    int exp_rr [6];
    int exp_bh [4];
    exp_rr = '{0, 1, 3, 0, 1, 3};
    exp_bh = '{1, 1, 1, 0};
    for (int i = 0; i < N; i++) acks[i] = 0;
    bus.tx_ack = 1'b0;
    bus.rx_end = 1'b0;
    clear_queues();
    tick();
    tick();
    check_eq("rst_tx_req", bus.tx_req, 0);
    check_eq("rst_tx_data", bus.tx_data, 0);
    check_eq("rst_req_ack", bus.req_ack, 0);
    check_eq("rst_grant_id", bus.grant_id, 0);
    check_eq("rst_busy", bus.busy, 0);
    check_eq("rst_timeout_err", bus.timeout_err, 0);
    rst = 1'b0;
    m_ptr = N - 1;
    m_own = -1;

    // Single byte from handler 2.
    load(2, 8'h10, 1'b1);
    drive_handlers();
    run_byte(1, 0);
    check_eq("single_grant", glog[glog.size()-1], 2);

    // Round-robin over handlers 0, 1, 3.
    do_reset();
    for (int r = 0; r < 2; r++) begin
      load(0, 8'h00 + 8'(r), 1'b1);
      load(1, 8'h10 + 8'(r), 1'b1);
      load(3, 8'h30 + 8'(r), 1'b1);
    end
    drive_handlers();
    base = glog.size();
    repeat (6) run_byte(0, 0);
    for (int i = 0; i < 6; i++) begin
      if (base + i < glog.size()) check_eq("rr_order", glog[base+i], exp_rr[i]);
      else check_eq("rr_missing", 0, 1);
    end

    // Burst hold: handler 1 keeps the grant across three bytes.
    load(0, 8'h55, 1'b1);
    drive_handlers();
    run_byte(0, 0);
    load(1, 8'hA1, 1'b0);
    load(1, 8'hA2, 1'b0);
    load(1, 8'hA3, 1'b1);
    load(0, 8'h66, 1'b1);
    drive_handlers();
    base = glog.size();
    a1 = acks[1];
    run_byte(2, 0);
    run_byte(0, 0);
    run_byte(1, 0);
    run_byte(0, 0);
    for (int i = 0; i < 4; i++) begin
      if (base + i < glog.size()) check_eq("burst_order", glog[base+i], exp_bh[i]);
      else check_eq("burst_missing", 0, 1);
    end
    check_eq("burst_acks", acks[1] - a1, 3);

    // rx_end while waiting for ack: next grant moves past the aborted handler.
    load(2, 8'h20, 1'b1);
    load(3, 8'h30, 1'b1);
    drive_handlers();
    run_byte(1, 2);
    run_byte(0, 0);
    check_eq("abort_next", glog[glog.size()-1], 3);
    run_byte(0, 0);

    // tx_ack together with rx_end in mid-burst.
    load(3, 8'hB1, 1'b0);
    load(3, 8'hB2, 1'b0);
    load(3, 8'hB3, 1'b1);
    drive_handlers();
    run_byte(0, 0);
    run_byte(1, 1);
    run_byte(0, 0);

    // Randomised traffic.
    for (int r = 0; r < 25; r++) begin
      int guard;
      clear_queues();
      for (int h = 0; h < N; h++) begin
        if ($urandom_range(3) != 0) begin
          int nb;
          nb = $urandom_range(1, 2);
          repeat (nb) begin
            int len;
            len = $urandom_range(1, 3);
            for (int j = 0; j < len; j++) load(h, 8'($urandom), (j == len - 1));
          end
        end
      end
      drive_handlers();
      guard = 0;
      while (pending() && guard < 200) begin
        int v;
        int mode;
        v = $urandom_range(0, 99);
        mode = (v < 70) ? 0 : (v < 85) ? 1 : 2;
        run_byte($urandom_range(0, 3), mode);
        guard++;
      end
    end

    // Asynchronous reset in the middle of a grant.
    do_reset();
    load(1, 8'h5A, 1'b1);
    load(2, 8'h6B, 1'b1);
    drive_handlers();
    wait_grant(lat);
    check_eq("pre_rst_grant", bus.grant_id, 1);
    rst = 1'b1;
    #1;
    check_eq("mid_rst_tx_req", bus.tx_req, 0);
    check_eq("mid_rst_busy", bus.busy, 0);
    check_eq("mid_rst_grant", bus.grant_id, 0);
    check_eq("mid_rst_tx_data", bus.tx_data, 0);
    clear_queues();
    tick();
    rst = 1'b0;
    m_ptr = N - 1;
    m_own = -1;
    load(0, 8'h01, 1'b1);
    load(2, 8'h02, 1'b1);
    drive_handlers();
    run_byte(0, 0);
    run_byte(0, 0);

    // No tx_ack at all.
    do_reset();
    load(0, 8'h77, 1'b1);
    drive_handlers();
    wait_grant(lat);
    check_eq("to_grant_lat", lat, 1);
    n = 0;
    terr = 0;
    na = 0;
`ifdef SPI_TX_ARB_TIMEOUT_EN
    do begin
      tick();
      n++;
      if (bus.timeout_err) terr++;
      if (bus.req_ack != 0) na++;
    end while (bus.tx_req && n < 40);
    check_eq("to_len_in_range", (n >= 15 && n <= 17), 1);
    check_eq("to_busy", bus.busy, 0);
    repeat (3) begin
      tick();
      if (bus.timeout_err) terr++;
      if (bus.req_ack != 0) na++;
    end
    check_eq("to_pulses", terr, 1);
    check_eq("to_no_ack", na, 0);
`else
    repeat (1000) begin
      tick();
      if (!bus.tx_req) n++;
      if (bus.timeout_err) terr++;
      if (bus.req_ack != 0) na++;
    end
    check_eq("no_to_drops", n, 0);
    check_eq("no_to_err", terr, 0);
    check_eq("no_to_ack", na, 0);
    bus.rx_end = 1'b1;
    tick();
    bus.rx_end = 1'b0;
    check_eq("no_to_rx_end", bus.tx_req, 0);
`endif
    do_reset();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
